// File: rtl/ex_alu_seq_pkg.sv
// rtl/ex_alu_seq_pkg.sv - shared constants, op codes and FSM encoding for the EX-stage ALU
package ex_alu_seq_pkg;

    localparam int DEF_XLEN    = 32;
    localparam int DEF_SHAMT_W = 5;

    localparam logic [3:0] ALUSEL_AND  = 4'b0000;
    localparam logic [3:0] ALUSEL_OR   = 4'b0001;
    localparam logic [3:0] ALUSEL_ADD  = 4'b0010;
    localparam logic [3:0] ALUSEL_XOR  = 4'b0011;
    localparam logic [3:0] ALUSEL_SUB  = 4'b0100;
    localparam logic [3:0] ALUSEL_SLL  = 4'b0101;
    localparam logic [3:0] ALUSEL_SRL  = 4'b0110;
    localparam logic [3:0] ALUSEL_SRA  = 4'b0111;
    localparam logic [3:0] ALUSEL_SLT  = 4'b1000;
    localparam logic [3:0] ALUSEL_SLTU = 4'b1001;
    localparam logic [3:0] ALUSEL_BR   = 4'b1010;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    function automatic logic is_shift_op(input logic [3:0] sel);
        return (sel == ALUSEL_SLL) || (sel == ALUSEL_SRL) || (sel == ALUSEL_SRA);
    endfunction

endpackage

// File: rtl/ex_alu_seq_if.sv
// rtl/ex_alu_seq_if.sv - operand/result bus between ALU control and the EX-stage ALU
// Signals: valid_in/ready_out/alusel/a/b (request), valid_out/result/zf/cf/vf/sf (response).
// master = upstream issuer, slave = ex_alu_seq.
interface ex_alu_seq_if #(
    parameter int XLEN = 32
);
    logic            valid_in;
    logic            ready_out;
    logic [3:0]      alusel;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            valid_out;
    logic [XLEN-1:0] result;
    logic            zf;
    logic            cf;
    logic            vf;
    logic            sf;

    modport master (
        output valid_in, alusel, a, b,
        input  ready_out, valid_out, result, zf, cf, vf, sf
    );

    modport slave (
        input  valid_in, alusel, a, b,
        output ready_out, valid_out, result, zf, cf, vf, sf
    );
endinterface

// File: rtl/ex_alu_seq_shift_iter.sv
// rtl/ex_alu_seq_shift_iter.sv - iterative one-bit-per-cycle shifter for SLL/SRL/SRA
// Ports: clk, rst_n, i_flush (abort), i_start/i_op/i_data/i_shamt (load, shamt>0),
//        o_done (final shift happens this cycle), o_data (value after this cycle's shift).
module ex_alu_seq_shift_iter
    import ex_alu_seq_pkg::*;
#(
    parameter int XLEN    = DEF_XLEN,
    parameter int SHAMT_W = DEF_SHAMT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_flush,
    input  logic               i_start,
    input  logic [3:0]         i_op,
    input  logic [XLEN-1:0]    i_data,
    input  logic [SHAMT_W-1:0] i_shamt,
    output logic               o_done,
    output logic [XLEN-1:0]    o_data
);

    logic [XLEN-1:0]    r_data;
    logic [SHAMT_W-1:0] r_count;
    logic [3:0]         r_op;
    logic               r_busy;
    logic [XLEN-1:0]    w_next;

    always_comb begin
        w_next = r_data;
        case (r_op)
            ALUSEL_SLL: w_next = {r_data[XLEN-2:0], 1'b0};
            ALUSEL_SRL: w_next = {1'b0, r_data[XLEN-1:1]};
            ALUSEL_SRA: w_next = {r_data[XLEN-1], r_data[XLEN-1:1]};
            default:    w_next = r_data;
        endcase
    end

    // done is asserted during the cycle that performs the last shift, so the
    // parent can register w_next on the same edge and keep latency at n+1.
    assign o_done = r_busy && (r_count == SHAMT_W'(1));
    assign o_data = w_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_count <= '0;
            r_op    <= '0;
            r_busy  <= 1'b0;
        end else if (i_flush) begin
            r_count <= '0;
            r_busy  <= 1'b0;
        end else if (i_start) begin
            r_data  <= i_data;
            r_count <= i_shamt;
            r_op    <= i_op;
            r_busy  <= 1'b1;
        end else if (r_busy) begin
            r_data  <= w_next;
            r_count <= r_count - SHAMT_W'(1);
            if (r_count == SHAMT_W'(1)) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ex_alu_seq.sv
// rtl/ex_alu_seq.sv - EX-stage execute unit: 1-cycle logic/arith/compare, iterative shifts
// Ports: clk, rst_n (async, active-low), flush (kill in-flight op), stall_in (freeze output,
//        block accept), bus (ex_alu_seq_if.slave: valid_in/ready_out/alusel/a/b in,
//        valid_out/result/zf/cf/vf/sf out).
module ex_alu_seq
    import ex_alu_seq_pkg::*;
#(
    parameter int XLEN    = DEF_XLEN,
    parameter int SHAMT_W = DEF_SHAMT_W
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        stall_in,
    ex_alu_seq_if.slave bus
);

    state_e          r_state;
    logic            r_ready;
    logic            r_valid;
    logic [XLEN-1:0] r_result;
    logic            r_zf;
    logic            r_cf;
    logic            r_vf;
    logic            r_sf;
    // Shift completion that arrived while stall_in was high waits here.
    logic            r_hold_valid;
    logic [XLEN-1:0] r_hold_result;

    logic               w_accept;
    logic [SHAMT_W-1:0] w_shamt;
    logic               w_is_sub;
    logic [XLEN-1:0]    w_b_op;
    logic [XLEN:0]      w_sum;
    logic               w_sum_vf;
    logic               w_slt;
    logic               w_sltu;
    logic [XLEN-1:0]    w_res;
    logic               w_cf;
    logic               w_vf;
    logic               w_sh_start;
    logic               w_sh_done;
    logic [XLEN-1:0]    w_sh_data;

    assign w_accept = bus.valid_in && r_ready && !stall_in;
    assign w_shamt  = bus.b[SHAMT_W-1:0];

    // SUB and BR share the adder: a + ~b + 1, so carry-out means "no borrow".
    assign w_is_sub = (bus.alusel == ALUSEL_SUB) || (bus.alusel == ALUSEL_BR);
    assign w_b_op   = w_is_sub ? ~bus.b : bus.b;
    assign w_sum    = {1'b0, bus.a} + {1'b0, w_b_op} + {{XLEN{1'b0}}, w_is_sub};
    assign w_sum_vf = (bus.a[XLEN-1] == w_b_op[XLEN-1]) && (w_sum[XLEN-1] != bus.a[XLEN-1]);
    assign w_slt    = $signed(bus.a) < $signed(bus.b);
    assign w_sltu   = bus.a < bus.b;

    always_comb begin
        w_res = '0;
        w_cf  = 1'b0;
        w_vf  = 1'b0;
        case (bus.alusel)
            ALUSEL_AND:  w_res = bus.a & bus.b;
            ALUSEL_OR:   w_res = bus.a | bus.b;
            ALUSEL_XOR:  w_res = bus.a ^ bus.b;
            ALUSEL_ADD, ALUSEL_SUB, ALUSEL_BR: begin
                w_res = w_sum[XLEN-1:0];
                w_cf  = w_sum[XLEN];
                w_vf  = w_sum_vf;
            end
            // Zero-amount shifts finish in one cycle with the operand unchanged.
            ALUSEL_SLL, ALUSEL_SRL, ALUSEL_SRA: w_res = bus.a;
            ALUSEL_SLT:  w_res = {{(XLEN-1){1'b0}}, w_slt};
            ALUSEL_SLTU: w_res = {{(XLEN-1){1'b0}}, w_sltu};
            default:     w_res = '0;
        endcase
    end

    assign w_sh_start = w_accept && is_shift_op(bus.alusel) && (w_shamt != '0);

    ex_alu_seq_shift_iter #(
        .XLEN    (XLEN),
        .SHAMT_W (SHAMT_W)
    ) u_shift (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (flush),
        .i_start (w_sh_start),
        .i_op    (bus.alusel),
        .i_data  (bus.a),
        .i_shamt (w_shamt),
        .o_done  (w_sh_done),
        .o_data  (w_sh_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_ready       <= 1'b0;
            r_valid       <= 1'b0;
            r_result      <= '0;
            r_zf          <= 1'b0;
            r_cf          <= 1'b0;
            r_vf          <= 1'b0;
            r_sf          <= 1'b0;
            r_hold_valid  <= 1'b0;
            r_hold_result <= '0;
        end else if (flush) begin
            r_state      <= ST_IDLE;
            r_ready      <= 1'b1;
            r_valid      <= 1'b0;
            r_hold_valid <= 1'b0;
        end else begin
            // valid_out is a single-cycle pulse unless the output is frozen.
            if (!stall_in) begin
                r_valid <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    r_ready <= 1'b1;
                    if (w_accept) begin
                        if (w_sh_start) begin
                            r_state <= ST_SHIFT;
                            r_ready <= 1'b0;
                        end else begin
                            r_result <= w_res;
                            r_zf     <= (w_res == '0);
                            r_cf     <= w_cf;
                            r_vf     <= w_vf;
                            r_sf     <= w_res[XLEN-1];
                            r_valid  <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (w_sh_done && stall_in) begin
                        r_hold_valid  <= 1'b1;
                        r_hold_result <= w_sh_data;
                    end else if (w_sh_done || (r_hold_valid && !stall_in)) begin
                        r_result     <= w_sh_done ? w_sh_data : r_hold_result;
                        r_zf         <= w_sh_done ? (w_sh_data == '0) : (r_hold_result == '0);
                        r_cf         <= 1'b0;
                        r_vf         <= 1'b0;
                        r_sf         <= w_sh_done ? w_sh_data[XLEN-1] : r_hold_result[XLEN-1];
                        r_valid      <= 1'b1;
                        r_hold_valid <= 1'b0;
                        r_state      <= ST_IDLE;
                        r_ready      <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready_out = r_ready;
    assign bus.valid_out = r_valid;
    assign bus.result    = r_result;
    assign bus.zf        = r_zf;
    assign bus.cf        = r_cf;
    assign bus.vf        = r_vf;
    assign bus.sf        = r_sf;

endmodule
